// File: rtl/mbox_fetch_buffer_pkg.sv
// Shared types and helpers for the MBOX fetch buffer slice.
// Optional build macro used by this slice: MBOX_FETCH_PARITY_EN.
package mbox_pkg;

    localparam int MBOX_AW = 32;
    localparam int MBOX_DW = 32;

    typedef logic [MBOX_AW-1:0] mbox_addr_t;
    typedef logic [MBOX_DW-1:0] mbox_data_t;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mbox_fetch_buffer_if.sv
// Bus bundle for mbox_fetch_buffer: upstream address stream, SRAM read port,
// consumer data stream and status.
// With MBOX_FETCH_PARITY_EN defined, the bundle also carries mem_rpar and perr.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// A source holding valid keeps its payload stable until the transfer; ready
// may change freely and never depends on a transfer already completing.
// addr_valid/addr_ready move upstream addresses in; dout_valid/dout_ready
// move FIFO head words out. dout_ready is ignored while dout_valid is low.
interface mbox_fetch_buffer_if #(
    parameter int AW = mbox_pkg::MBOX_AW,
    parameter int DW = mbox_pkg::MBOX_DW,
    parameter int LW = mbox_pkg::level_width(4)
) ();

    logic          addr_valid;
    logic [AW-1:0] addr;
    logic          addr_ready;
    logic          flush;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          dout_valid;
    logic [DW-1:0] dout;
    logic          dout_ready;
    logic [LW-1:0] level;
    logic          busy;
`ifdef MBOX_FETCH_PARITY_EN
    logic          mem_rpar;
    logic          perr;
`endif

    // Block side.
    modport slave (
        input  addr_valid, addr, flush, mem_rdata, dout_ready,
`ifdef MBOX_FETCH_PARITY_EN
        input  mem_rpar,
        output perr,
`endif
        output addr_ready, mem_re, mem_addr, dout_valid, dout, level, busy
    );

    // Environment side: address source, SRAM and consumer.
    modport master (
        output addr_valid, addr, flush, mem_rdata, dout_ready,
`ifdef MBOX_FETCH_PARITY_EN
        output mem_rpar,
        input  perr,
`endif
        input  addr_ready, mem_re, mem_addr, dout_valid, dout, level, busy
    );

endinterface

// File: rtl/mbox_fetch_buffer_fifo.sv
// Synchronous FIFO for returned mailbox words. Flush empties it in one cycle
// and takes priority over push/pop in that cycle. rdata shows the head entry
// and reads as zero while empty.
module mbox_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; entries need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/mbox_fetch_buffer.sv
// MBOX fetch buffer: turns the upstream word-address stream into single-word
// SRAM reads and buffers the returned words for the consumer. Reads are only
// issued when a FIFO slot is reserved for them (level + inflight < DEPTH), so
// a return always has room. A flush drops buffered and in-flight words.
// Optional build macro: MBOX_FETCH_PARITY_EN (odd parity check on returns,
// sticky perr output).
module mbox_fetch_buffer
    import mbox_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 2,
    parameter int AW     = MBOX_AW,
    parameter int DW     = MBOX_DW
) (
    input  logic                clk,
    input  logic                rst_n,
    mbox_fetch_buffer_if.slave  bus
);

    localparam int LW = level_width(DEPTH);
    localparam int IW = $clog2(RD_LAT + 1);
    localparam int CW = ((LW > IW) ? LW : IW) + 1;
`ifdef MBOX_FETCH_PARITY_EN
    localparam int FW = DW + 1;
`else
    localparam int FW = DW;
`endif

    logic [RD_LAT-1:0] vpipe;
    logic [RD_LAT-1:0] vpipe_next;
    logic [IW-1:0]     inflight;
    logic [CW-1:0]     credits_used;
    logic              addr_ready;
    logic              accept;
    logic              ret;
    logic              push;
    logic              pop;
    logic [LW-1:0]     level;
    logic              fifo_empty;
    logic              fifo_full;
    logic [FW-1:0]     fifo_wdata;
    logic [FW-1:0]     fifo_rdata;

    // Every buffered word and every outstanding read holds one FIFO credit.
    assign credits_used = CW'(level) + CW'(inflight);
    assign addr_ready   = rst_n && !bus.flush && (credits_used < CW'(DEPTH));
    assign accept       = bus.addr_valid && addr_ready;

    // The read is issued combinationally in the accept cycle.
    assign bus.addr_ready = addr_ready;
    assign bus.mem_re     = accept;
    assign bus.mem_addr   = accept ? bus.addr : '0;

    // The oldest pipe stage lines up with mem_rdata being valid.
    assign ret  = vpipe[RD_LAT-1];
    assign push = ret && !bus.flush;
    assign pop  = !fifo_empty && bus.dout_ready && !bus.flush;

    // Next value of the read-valid pipe: shift toward the output, new read enters at bit 0.
    always_comb begin
        vpipe_next    = vpipe << 1;
        vpipe_next[0] = accept;
    end

    // Read-valid pipe and outstanding-read count; flush forgets every read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe    <= '0;
            inflight <= '0;
        end else if (bus.flush) begin
            vpipe    <= '0;
            inflight <= '0;
        end else begin
            vpipe <= vpipe_next;
            case ({accept, ret})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef MBOX_FETCH_PARITY_EN
    logic perr_q;

    assign fifo_wdata = {bus.mem_rpar, bus.mem_rdata};
    assign bus.perr   = perr_q;

    // Sticky odd-parity error on any word written into the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else if (bus.flush) begin
            perr_q <= 1'b0;
        end else if (push && !(^{bus.mem_rdata, bus.mem_rpar})) begin
            perr_q <= 1'b1;
        end
    end
`else
    assign fifo_wdata = bus.mem_rdata;
`endif

    mbox_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (FW),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.flush),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign bus.dout_valid = !fifo_empty;
    assign bus.dout       = fifo_rdata[DW-1:0];
    assign bus.level      = level;
    assign bus.busy       = (level != '0) || (inflight != '0);

    // A returning word must always find a free slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !fifo_full)
        else $error("fifo written while full");

endmodule

// File: tb/tb_mbox_fetch_buffer.sv
// Self-checking bench for mbox_fetch_buffer with a queue-level reference model
// and a fixed-latency SRAM model.
module tb_mbox_fetch_buffer;
    import mbox_pkg::*;

    localparam int DEPTH  = 4;
    localparam int RD_LAT = 2;
    localparam int AW     = MBOX_AW;
    localparam int DW     = MBOX_DW;
    localparam int LW     = level_width(DEPTH);

    logic clk;
    logic rst_n;

    mbox_fetch_buffer_if #(.AW(AW), .DW(DW), .LW(LW)) bus ();

    mbox_fetch_buffer #(
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .AW     (AW),
        .DW     (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- SRAM contents ----------------
    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        if (a == 32'h200) return 32'h0000_0001;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // Correct odd parity everywhere except address 0x200, which is deliberately bad.
    function automatic logic par_of(input logic [AW-1:0] a);
        if (a == 32'h200) return 1'b1;
        return ~(^word_of(a));
    endfunction

    // Fixed-latency SRAM: data for a read issued in cycle t is presented in t+RD_LAT.
    logic [DW-1:0] rd_data [RD_LAT];
    logic          rd_par  [RD_LAT];
    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
            rd_data[i] <= rd_data[i-1];
            rd_par[i]  <= rd_par[i-1];
        end
        rd_data[0] <= bus.mem_re ? word_of(bus.mem_addr) : DW'($urandom());
        rd_par[0]  <= bus.mem_re ? par_of(bus.mem_addr) : 1'($urandom());
    end
    assign bus.mem_rdata = rd_data[RD_LAT-1];
`ifdef MBOX_FETCH_PARITY_EN
    assign bus.mem_rpar = rd_par[RD_LAT-1];
`endif

    // ---------------- scoreboard / reference model ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q [$];   // words expected in the FIFO, head first
    int            ret_q [$];   // return cycle of each outstanding read
    logic [AW-1:0] pend_q[$];   // address of each outstanding read
    int            cyc = 0;
    logic          exp_perr = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        ret_q.delete();
        pend_q.delete();
        exp_perr = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: drive at the falling edge, compare just after, then
    // advance the model across the following rising edge.
    task automatic drive_cycle(input logic av, input logic [AW-1:0] a, input logic dr,
                               input logic fl, output logic acc);
        logic exp_ready;
        logic [DW-1:0] w;
        @(negedge clk);
        bus.addr_valid = av;
        bus.addr       = a;
        bus.dout_ready = dr;
        bus.flush      = fl;
        #1;
        exp_ready = !fl && ((exp_q.size() + ret_q.size()) < DEPTH);
        acc       = av && exp_ready;
        check("addr_ready", bus.addr_ready, exp_ready);
        check("mem_re",     bus.mem_re, acc);
        check("mem_addr",   bus.mem_addr, acc ? a : '0);
        check("dout_valid", bus.dout_valid, exp_q.size() != 0);
        check("dout",       bus.dout, (exp_q.size() != 0) ? exp_q[0] : '0);
        check("level",      bus.level, exp_q.size());
        check("busy",       bus.busy, (exp_q.size() + ret_q.size()) != 0);
`ifdef MBOX_FETCH_PARITY_EN
        check("perr",       bus.perr, exp_perr);
`endif
        if (fl) begin
            model_clear();
        end else begin
            if (exp_q.size() != 0 && dr) void'(exp_q.pop_front());
            if (ret_q.size() != 0 && ret_q[0] == cyc) begin
                w = word_of(pend_q[0]);
                exp_q.push_back(w);
                if ((^{w, par_of(pend_q[0])}) == 1'b0) exp_perr = 1'b1;
                void'(ret_q.pop_front());
                void'(pend_q.pop_front());
            end
            if (acc) begin
                ret_q.push_back(cyc + RD_LAT);
                pend_q.push_back(a);
            end
        end
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr_ready"}, bus.addr_ready, 1'b0);
        check({tag, "_mem_re"},     bus.mem_re, 1'b0);
        check({tag, "_mem_addr"},   bus.mem_addr, '0);
        check({tag, "_dout_valid"}, bus.dout_valid, 1'b0);
        check({tag, "_dout"},       bus.dout, '0);
        check({tag, "_level"},      bus.level, '0);
        check({tag, "_busy"},       bus.busy, 1'b0);
`ifdef MBOX_FETCH_PARITY_EN
        check({tag, "_perr"},       bus.perr, 1'b0);
`endif
    endtask

    // Assert reset mid-cycle with addr_valid high, check outputs drop at once.
    task automatic reset_mid(input logic [AW-1:0] a);
        @(negedge clk);
        bus.addr_valid = 1'b1;
        bus.addr       = a;
        bus.dout_ready = 1'b0;
        bus.flush      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        model_clear();
        repeat (2) @(negedge clk);
        bus.addr_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    // Single read of 0x100 from an empty buffer, with absolute expectations.
    task automatic single_read(input string tag);
        logic acc;
        drive_cycle(1'b1, 32'h100, 1'b0, 1'b0, acc);
        check({tag, "_mem_re"},   bus.mem_re, 1'b1);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'h100);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
        check({tag, "_not_yet"},  bus.dout_valid, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
        check({tag, "_valid"},    bus.dout_valid, 1'b1);
        check({tag, "_dout"},     bus.dout, 32'hDEADBEEF);
        check({tag, "_level"},    bus.level, 1);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    // ---------------- main sequence ----------------
    logic [AW-1:0] next_addr;
    logic [AW-1:0] pop_addr;
    logic          acc;
    int            n_re;

    initial begin
        rst_n          = 1'b0;
        bus.addr_valid = 1'b0;
        bus.addr       = '0;
        bus.dout_ready = 1'b0;
        bus.flush      = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single read latency.
        single_read("single");

        // Burst of 8 with the consumer stalled: only DEPTH reads get credits.
        next_addr = '0;
        n_re = 0;
        repeat (8) begin
            drive_cycle(1'b1, next_addr, 1'b0, 1'b0, acc);
            if (bus.mem_re) n_re++;
            if (acc) next_addr += 4;
        end
        check("burst_accepts", n_re, DEPTH);
        check("burst_level", bus.level, DEPTH);
        check("burst_ready", bus.addr_ready, 1'b0);

        // Drain while the address stream continues; words leave in address order.
        pop_addr = '0;
        repeat (16) begin
            drive_cycle(1'b1, next_addr, 1'b1, 1'b0, acc);
            if (bus.dout_valid) begin
                check("drain_order", bus.dout, word_of(pop_addr));
                pop_addr += 4;
            end
            if (acc) next_addr += 4;
        end
        repeat (6) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
            if (bus.dout_valid) begin
                check("drain_order", bus.dout, word_of(pop_addr));
                pop_addr += 4;
            end
        end
        check("drain_complete", pop_addr, next_addr);

        // Flush with two words buffered and two reads in flight.
        drive_cycle(1'b1, 32'h400, 1'b0, 1'b0, acc);
        drive_cycle(1'b1, 32'h404, 1'b0, 1'b0, acc);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
        drive_cycle(1'b1, 32'h408, 1'b0, 1'b0, acc);
        drive_cycle(1'b1, 32'h40C, 1'b0, 1'b0, acc);
        check("preflush_level", bus.level, 2);
        check("preflush_busy",  bus.busy, 1'b1);
        drive_cycle(1'b1, 32'h410, 1'b1, 1'b1, acc);
        check("flush_ready",    bus.addr_ready, 1'b0);
        check("flush_no_read",  bus.mem_re, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("postflush_level", bus.level, 0);
        check("postflush_valid", bus.dout_valid, 1'b0);
        repeat (RD_LAT) drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("postflush_busy",  bus.busy, 1'b0);
        check("postflush_level2", bus.level, 0);

        // Reset in the middle of a burst.
        drive_cycle(1'b1, 32'h800, 1'b0, 1'b0, acc);
        drive_cycle(1'b1, 32'h804, 1'b0, 1'b0, acc);
        reset_mid(32'h808);
        single_read("after_reset");

`ifdef MBOX_FETCH_PARITY_EN
        // Bad parity word: perr rises the cycle after the write and holds until flush.
        drive_cycle(1'b1, 32'h200, 1'b0, 1'b0, acc);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
        check("perr_before", bus.perr, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("perr_set", bus.perr, 1'b1);
        check("perr_data", bus.dout, 32'h0000_0001);
        repeat (3) drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("perr_sticky", bus.perr, 1'b1);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
        check("perr_cleared", bus.perr, 1'b0);
`endif

        // Throughput: always-valid source and always-ready consumer.
        next_addr = 32'h1000;
        n_re = 0;
        repeat (40) begin
            drive_cycle(1'b1, next_addr, 1'b1, 1'b0, acc);
            if (bus.mem_re) n_re++;
            if (acc) next_addr += 4;
        end
        check("throughput", n_re, 40);

        // Randomized traffic with occasional flushes.
        next_addr = 32'($urandom_range(0, 16'hFFFF)) << 2;
        repeat (600) begin
            logic av, dr, fl;
            av = ($urandom_range(0, 9) < 7);
            dr = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 39) == 0);
            drive_cycle(av, next_addr, dr, fl, acc);
            if (acc) next_addr += 4;
        end
        repeat (8) drive_cycle(1'b0, '0, 1'b1, 1'b0, acc);
        check("final_idle", bus.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
